// File: rtl/popcount_acc_array_pkg.sv
// Shared types and default sizing for the popcount accumulator array.
package popcount_acc_array_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_IN_W   = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LEN_W  = 16;

endpackage

// File: rtl/popcount_acc_array_acc_lane.sv
// One channel: load/add of a signed popcount with sticky overflow; one-cycle update, no backpressure of its own.
// POPCOUNT_ACC_SAT_EN selects clamping on overflow, otherwise the sum wraps.
module acc_lane
  import popcount_acc_array_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             add,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc,
  output logic             ovf
);

  logic signed [IN_W-1:0] din_s;
  logic signed [ACC_W:0]  din_x;
  logic signed [ACC_W:0]  acc_x;
  logic signed [ACC_W:0]  sum;
  logic                   ovf_add;
  logic [ACC_W-1:0]       add_res;

  assign din_s = din;
  assign din_x = (ACC_W+1)'(din_s);
  assign acc_x = (ACC_W+1)'($signed(acc));

  // One guard bit: the two top bits disagree exactly when the ACC_W result is out of range.
  assign sum     = acc_x + din_x;
  assign ovf_add = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    add_res = sum[ACC_W-1:0];
`ifdef POPCOUNT_ACC_SAT_EN
    if (ovf_add) begin
      add_res = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= din_x[ACC_W-1:0];
      ovf <= 1'b0;
    end else if (add) begin
      acc <= add_res;
      ovf <= ovf | ovf_add;
    end
  end

endmodule

// File: rtl/popcount_acc_array.sv
// Per-channel frame accumulator: result valid 1 cycle after the last beat; in_ready drops while a result is held.
// Build option POPCOUNT_ACC_SAT_EN: saturate channel sums instead of wrapping.
module popcount_acc_array
  import popcount_acc_array_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0]        frame_len,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*ACC_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_ovf
);

  state_t           state;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_eff;
  logic             hs;
  logic             first;
  logic             last;

  assign hs    = in_valid & in_ready;
  assign first = (beat_cnt == '0);

  // Length is taken live on beat 0 (zero means one beat), then frozen for the frame.
  always_comb begin
    len_eff = len_q;
    if (first) begin
      len_eff = (frame_len == '0) ? LEN_W'(1) : frame_len;
    end
  end

  assign last = (beat_cnt == len_eff - LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      beat_cnt  <= '0;
      len_q     <= LEN_W'(1);
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (hs) begin
            if (first) len_q <= len_eff;
            if (last) begin
              state     <= HOLD;
              beat_cnt  <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        HOLD: begin
          // Release only; the next beat is taken no earlier than the following edge.
          if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (hs & first),
      .add  (hs & ~first),
      .din  (in_data[c*IN_W +: IN_W]),
      .acc  (out_data[c*ACC_W +: ACC_W]),
      .ovf  (out_ovf[c])
    );
  end

endmodule
